tia_horizontal_timing: RTL and testbench

TIA_HORIZONTAL_TIMING -- requirements
Module: tia_horizontal_timing

---
 rtl/tia_pkg.sv | 27 ++
 rtl/tia_hphase_gen.sv | 37 +++
 rtl/tia_horizontal_timing.sv | 83 ++++++++
 tb/tb_tia_horizontal_timing.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_pkg.sv
// Shared constants for the TIA horizontal timing chain: LFSR decode patterns,
// reload value, lockup pattern, biphase states and the LFSR step function.
package tia_pkg;

    localparam logic [5:0] HPAT_RESET  = 6'b000000;
    localparam logic [5:0] HPAT_LOCKUP = 6'b111111;
    localparam logic [5:0] HPAT_SHS    = 6'b111100;
    localparam logic [5:0] HPAT_RHS    = 6'b110111;
    localparam logic [5:0] HPAT_RCB    = 6'b001111;
    localparam logic [5:0] HPAT_RHB    = 6'b011100;
    localparam logic [5:0] HPAT_LRHB   = 6'b010111;
    localparam logic [5:0] HPAT_CNT    = 6'b101100;
    localparam logic [5:0] HPAT_SHB    = 6'b010100;

    typedef enum logic [1:0] {
        PHASE_0 = 2'd0,
        PHASE_1 = 2'd1,
        PHASE_2 = 2'd2,
        PHASE_3 = 2'd3
    } hphase_t;

    // XNOR feedback; the all-ones state maps onto itself.
    function automatic logic [5:0] hlfsrNext(input logic [5:0] cur);
        return {~(cur[0] ^ cur[1]), cur[5:1]};
    endfunction

endpackage

// File: rtl/tia_hphase_gen.sv
// Biphase horizontal clock generator: a four-state phase counter advanced on
// every colour clock, with hphi1 in phase 1 and hphi2 in phase 3.
module tia_hphase_gen
    import tia_pkg::*;
(
    input  logic clk_i,
    input  logic rsyn_i,
    output logic hphi1_o,
    output logic hphi2_o
);

    hphase_t phase_q;
    hphase_t phase_d;

    always_ff @(posedge clk_i) begin
        if (rsyn_i) begin
            phase_q <= PHASE_0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = PHASE_0;
        unique case (phase_q)
            PHASE_0: phase_d = PHASE_1;
            PHASE_1: phase_d = PHASE_2;
            PHASE_2: phase_d = PHASE_3;
            PHASE_3: phase_d = PHASE_0;
            default: phase_d = PHASE_0;
        endcase
    end

    assign hphi1_o = (phase_q == PHASE_1);
    assign hphi2_o = (phase_q == PHASE_3);

endmodule

// File: rtl/tia_horizontal_timing.sv
// TIA horizontal timing: 6-bit polynomial counter stepped once per 4 colour
// clocks, line-end reload, reset latching and decoding. Optional macro
// TIA_HLFSR_LOCKUP_RECOVER_EN makes the 111111 lockup state reload like shb.
module tia_horizontal_timing
    import tia_pkg::*;
(
    input  logic       clk,
    input  logic       rsyn,
    output logic       hphi1,
    output logic       hphi2,
    output logic       rsynl,
    output logic [5:0] out,
    output logic       shb,
    output logic       rsynd,
    output logic       shs,
    output logic       rhs,
    output logic       rcb,
    output logic       rhb,
    output logic       lrhb,
    output logic       cnt
);

    logic [5:0] out_q;
    logic [5:0] out_d;
    logic       rsynl_q;
    logic       rsynl_d;
    logic       rsynd_q;
    logic       rsynd_d;
    logic       advance;
    logic       lockup;

    tia_hphase_gen uPhaseGen (
        .clk_i   (clk),
        .rsyn_i  (rsyn),
        .hphi1_o (hphi1),
        .hphi2_o (hphi2)
    );

    // The counter steps on the edge that ends phase 3, i.e. while hphi2 is high.
    assign advance = hphi2;

`ifdef TIA_HLFSR_LOCKUP_RECOVER_EN
    assign lockup = (out_q == HPAT_LOCKUP);
`else
    assign lockup = 1'b0;
`endif

    assign shb = (out_q == HPAT_SHB) | rsynl_q | lockup;

    always_comb begin
        out_d   = out_q;
        rsynl_d = rsynl_q;
        rsynd_d = rsynd_q;
        if (advance) begin
            out_d   = shb ? HPAT_RESET : hlfsrNext(out_q);
            rsynl_d = 1'b0;
            rsynd_d = rsynl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rsyn) begin
            out_q   <= HPAT_RESET;
            rsynl_q <= 1'b1;
            rsynd_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            rsynl_q <= rsynl_d;
            rsynd_q <= rsynd_d;
        end
    end

    assign out   = out_q;
    assign rsynl = rsynl_q;
    assign rsynd = rsynd_q;
    assign shs   = (out_q == HPAT_SHS);
    assign rhs   = (out_q == HPAT_RHS);
    assign rcb   = (out_q == HPAT_RCB);
    assign rhb   = (out_q == HPAT_RHB);
    assign lrhb  = (out_q == HPAT_LRHB);
    assign cnt   = (out_q == HPAT_CNT);

endmodule

// File: tb/tb_tia_horizontal_timing.sv
// Self-checking bench for tia_horizontal_timing: vector table, line-level
// sequences, lockup deposit and a randomized run against a line-count model.
module tb_tia_horizontal_timing;

    logic       clk = 1'b0;
    logic       rsyn = 1'b1;
    logic       hphi1, hphi2, rsynl, shb, rsynd;
    logic       shs, rhs, rcb, rhb, lrhb, cnt;
    logic [5:0] out;
    logic [16:0] dutVec;

    int checks = 0;
    int errors = 0;

    // Model state: phase count, position within the line, latched resets.
    int         mPhase = 0;
    int         mIdx = 0;
    bit         mRsynl = 1'b0;
    bit         mRsynd = 1'b0;
    logic [5:0] lfsrTable [0:56];

    typedef struct {
        logic       rsyn;
        int         n;
        logic [5:0] outExp;
        logic       h1, h2, rl, rd, shbE, shsE;
    } vec_t;

    vec_t vecs [13];

    logic [16:0] samp [0:599];

    tia_horizontal_timing dut (
        .clk   (clk),
        .rsyn  (rsyn),
        .hphi1 (hphi1),
        .hphi2 (hphi2),
        .rsynl (rsynl),
        .out   (out),
        .shb   (shb),
        .rsynd (rsynd),
        .shs   (shs),
        .rhs   (rhs),
        .rcb   (rcb),
        .rhb   (rhb),
        .lrhb  (lrhb),
        .cnt   (cnt)
    );

    assign dutVec = {out, hphi1, hphi2, rsynl, rsynd, shb, shs, rhs, rcb, rhb, lrhb, cnt};

    always #5 clk = ~clk;

    function automatic void modelStep(input logic r);
        bit endOfLine;
        if (r) begin
            mPhase = 0;
            mIdx   = 0;
            mRsynl = 1'b1;
            mRsynd = 1'b0;
        end else begin
            if (mPhase == 3) begin
                endOfLine = (mIdx == 56) || mRsynl;
                mRsynd    = mRsynl;
                mRsynl    = 1'b0;
                mIdx      = endOfLine ? 0 : mIdx + 1;
            end
            mPhase = (mPhase + 1) % 4;
        end
    endfunction

    function automatic logic [16:0] modelVec();
        return {lfsrTable[mIdx], mPhase == 1, mPhase == 3, mRsynl, mRsynd,
                (mIdx == 56) || mRsynl, mIdx == 4, mIdx == 8, mIdx == 12,
                mIdx == 16, mIdx == 18, mIdx == 36};
    endfunction

    task automatic applyStimulus(input logic r);
        rsyn = r;
        @(posedge clk);
        modelStep(r);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    initial begin
        int         r1, r2, found, pulseLen, rsyndAt, badCount, holdLeft;
        bit         seenLow, sawZero;
        logic [5:0] p;
        int         decBit [6];
        int         decCount [6];
        string      decName [6];

        lfsrTable[0] = 6'b000000;
        for (int k = 1; k <= 56; k++) begin
            p = lfsrTable[k-1];
            lfsrTable[k] = {~(p[0] ^ p[1]), p[5:1]};
        end

        decBit   = '{5, 4, 3, 2, 1, 0};
        decCount = '{4, 8, 12, 16, 18, 36};
        decName  = '{"shs", "rhs", "rcb", "rhb", "lrhb", "cnt"};

        vecs[0]  = '{1'b1, 1, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4, 6'b110000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4, 6'b111000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4, 6'b111100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3, 6'b111100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1, 6'b111110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 3, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            for (int k = 0; k < vecs[i].n; k++) applyStimulus(vecs[i].rsyn);
            checkOutput($sformatf("vec%0d", i), dutVec,
                        {vecs[i].outExp, vecs[i].h1, vecs[i].h2, vecs[i].rl, vecs[i].rd,
                         vecs[i].shbE, vecs[i].shsE, 5'b00000});
        end

        $display("[TB] full line timing");
        applyStimulus(1'b1);
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b0);
            samp[i] = dutVec;
        end
        r1 = -1;
        r2 = -1;
        for (int i = 4; i < 600; i++) begin
            if (samp[i][6] && !samp[i-1][6]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        if (r1 < 0 || r2 < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL shb rises found r1=%0d r2=%0d expected two", r1, r2);
        end else begin
            checkCount("first shb rise", r1, 227);
            checkCount("shb period", r2 - r1, 228);
            for (int d = 0; d < 6; d++) begin
                found = -1;
                badCount = 0;
                for (int i = r1; i < r2; i++) begin
                    if (samp[i][decBit[d]]) begin
                        badCount++;
                        if (found < 0) found = i - r1;
                    end
                end
                checkCount({decName[d], " width"}, badCount, 4);
                checkCount({decName[d], " offset"}, found, 4 + 4 * decCount[d]);
            end
        end

        $display("[TB] rsyn pulse mid-line");
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            applyStimulus(1'b0);
            if (shb && !rsynl) found = 1;
        end
        checkCount("line start found", found, 1);
        for (int i = 0; i < 4 + 99; i++) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("pulse state", {9'd0, out, rsynl, rsynd}, {9'd0, 6'b000000, 1'b1, 1'b0});
        pulseLen = 1;
        rsyndAt = -1;
        seenLow = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0);
            if (!seenLow && rsynl) pulseLen++;
            else seenLow = 1'b1;
            if (rsynd && rsyndAt < 0) rsyndAt = k;
        end
        checkCount("rsynl length", pulseLen, 4);
        checkCount("rsynd lag", rsyndAt, 4);

        $display("[TB] lockup deposit");
        applyStimulus(1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0);
        for (int i = 0; i < 8 && !hphi2; i++) applyStimulus(1'b0);
        checkCount("hphi2 before deposit", int'(hphi2), 1);
        force dut.out_q = 6'b111111;
        applyStimulus(1'b0);
        release dut.out_q;
        #1;
        sawZero = (out == 6'b000000);
        badCount = (out != 6'b111111) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0);
            if (out == 6'b000000) sawZero = 1'b1;
            if (out != 6'b111111) badCount++;
        end
`ifdef TIA_HLFSR_LOCKUP_RECOVER_EN
        checkCount("lockup recovered", int'(sawZero), 1);
`else
        checkCount("lockup persists", badCount, 0);
        checkOutput("lockup out", {11'd0, out}, {11'd0, 6'b111111});
`endif

        $display("[TB] randomized run");
        applyStimulus(1'b1);
        checkOutput("random reset", dutVec, modelVec());
        holdLeft = 0;
        for (int i = 0; i < 2500; i++) begin
            if (holdLeft == 0 && $urandom_range(0, 299) == 0) holdLeft = $urandom_range(1, 3);
            if (holdLeft > 0) begin
                applyStimulus(1'b1);
                holdLeft--;
            end else begin
                applyStimulus(1'b0);
            end
            checkOutput($sformatf("random@%0d", i), dutVec, modelVec());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
